exec_cont: RTL and testbench

- Execute-stage controller of the accumulator processor, directly downstream of the fetch controller and stage register.
- Accepts a fetched 8-bit instruction through a valid/ready handshake, decodes it, and sequences data-RAM access.
- Owns the accumulator, zero flag and carry flag.
- Requests PC reloads for jumps; stops the machine on HLT.

---
 rtl/exec_cont.sv | 172 +++++++++++++++++
 tb/tb_exec_cont.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cont.sv
// exec_cont: execute-stage controller of the accumulator processor.
// Takes an instruction {opcode[2:0], operand[AW-1:0]} from the stage register over a
// valid/ready handshake, sequences data-RAM reads and writes, and owns the accumulator
// and the zero and carry flags. Jumps request a PC reload. HLT stops the machine until
// the next reset.
//
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   instr_valid, instr_in incoming instruction from the stage register
//   exec_ready            high only in IDLE; an instruction is accepted on valid & ready
//   dmem_en/we/addr/wdata data-RAM request (wdata is always the accumulator)
//   dmem_rdata            data-RAM read data, valid one cycle after the read request
//   pc_load, pc_load_val  one-cycle PC reload request and jump target
//   acc_out, z_flag, c_flag, halted  architectural state
// All outputs are decoded from registered state only.
module exec_cont #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [AW+2:0] instr_in,
    output logic          exec_ready,
    output logic          dmem_en,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    output logic          pc_load,
    output logic [AW-1:0] pc_load_val,
    output logic [DW-1:0] acc_out,
    output logic          z_flag,
    output logic          c_flag,
    output logic          halted
);

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpLda = 3'b001;
    localparam logic [2:0] OpSta = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpJmp = 3'b101;
    localparam logic [2:0] OpJz  = 3'b110;
    localparam logic [2:0] OpHlt = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StMemRd,
        StExec,
        StWrite,
        StHalt
    } stateT;

    stateT         stateQ, stateD;
    logic [AW+2:0] irQ, irD;
    logic [DW-1:0] accQ, accD;
    logic          zQ, zD;
    logic          cQ, cD;

    logic [2:0]    opcode;
    logic [AW-1:0] operand;
    logic [DW:0]   sum;
    logic [DW:0]   diff;

    assign opcode  = irQ[AW+2:AW];
    assign operand = irQ[AW-1:0];

    // One extra bit carries out of the add; in the subtract it goes high exactly when
    // acc < rdata, which is the borrow.
    assign sum  = {1'b0, accQ} + {1'b0, dmem_rdata};
    assign diff = {1'b0, accQ} - {1'b0, dmem_rdata};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            irQ    <= '0;
            accQ   <= '0;
            zQ     <= 1'b1;
            cQ     <= 1'b0;
        end else begin
            stateQ <= stateD;
            irQ    <= irD;
            accQ   <= accD;
            zQ     <= zD;
            cQ     <= cD;
        end
    end

    // Next-state and datapath update
    always_comb begin
        stateD = stateQ;
        irD    = irQ;
        accD   = accQ;
        zD     = zQ;
        cD     = cQ;
        unique case (stateQ)
            StIdle: begin
                if (instr_valid) begin
                    irD    = instr_in;
                    stateD = StDecode;
                end
            end
            StDecode: begin
                unique case (opcode)
                    OpLda, OpAdd, OpSub: stateD = StMemRd;
                    OpSta:               stateD = StWrite;
                    OpHlt:               stateD = StHalt;
                    default:             stateD = StIdle;  // NOP, JMP, JZ
                endcase
            end
            StMemRd: stateD = StExec;
            StExec: begin
                unique case (opcode)
                    OpAdd: {cD, accD} = sum;
                    OpSub: begin
                        accD = diff[DW-1:0];
                        cD   = diff[DW];
                    end
                    default: accD = dmem_rdata;  // LDA leaves carry alone
                endcase
                zD     = (accD == '0);
                stateD = StIdle;
            end
            StWrite: stateD = StIdle;
            StHalt:  stateD = StHalt;
            default: stateD = StIdle;
        endcase
    end

    // Moore output decode
    always_comb begin
        exec_ready  = 1'b0;
        dmem_en     = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        halted      = 1'b0;
        unique case (stateQ)
            StIdle: exec_ready = 1'b1;
            StDecode: begin
                if (opcode == OpJmp) begin
                    pc_load     = 1'b1;
                    pc_load_val = operand;
                end else if (opcode == OpJz) begin
                    pc_load     = zQ;
                    pc_load_val = operand;
                end
            end
            StMemRd: begin
                dmem_en   = 1'b1;
                dmem_addr = operand;
            end
            StWrite: begin
                dmem_en   = 1'b1;
                dmem_we   = 1'b1;
                dmem_addr = operand;
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign dmem_wdata = accQ;
    assign acc_out    = accQ;
    assign z_flag     = zQ;
    assign c_flag     = cQ;

endmodule

// File: tb/tb_exec_cont.sv
// Testbench for exec_cont: directed vector table plus hand-written sequences for
// HLT, asynchronous reset and reset during a memory read.
module tb_exec_cont;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr_in;
    logic       exec_ready;
    logic       dmem_en;
    logic       dmem_we;
    logic [4:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       pc_load;
    logic [4:0] pc_load_val;
    logic [7:0] acc_out;
    logic       z_flag;
    logic       c_flag;
    logic       halted;

    exec_cont #(
        .DW(8),
        .AW(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .exec_ready  (exec_ready),
        .dmem_en     (dmem_en),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .acc_out     (acc_out),
        .z_flag      (z_flag),
        .c_flag      (c_flag),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data RAM model: data appears the cycle after the request.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (dmem_en && !dmem_we) dmem_rdata <= mem[dmem_addr];
    end

    int nApplied = 0;
    int nMis     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [7:0] memVal;   // preloaded at the operand address for reads
        logic [7:0] expAcc;
        logic       expZ;
        logic       expC;
        int         expLat;   // accept edge to first edge with exec_ready high
        int         expPc;    // pc_load pulses
        logic [4:0] expPcVal;
        int         expWr;
        int         expRd;
    } vecT;

    vecT vecs[15];

    // Starts at a negedge in IDLE, returns at the negedge where exec_ready is back.
    task automatic runInstr(input logic [7:0] ins, output int lat, output int pcN,
                            output logic [4:0] pcV, output int wrN, output logic [4:0] wrA,
                            output logic [7:0] wrD, output int rdN, output logic [4:0] rdA,
                            output int addrBad);
        lat = 0; pcN = 0; pcV = '0; wrN = 0; wrA = '0; wrD = '0;
        rdN = 0; rdA = '0; addrBad = 0;
        instr_in    = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_in    = 8'h00;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (pc_load) begin
                pcN++;
                pcV = pc_load_val;
            end
            if (dmem_en && dmem_we) begin
                wrN++;
                wrA = dmem_addr;
                wrD = dmem_wdata;
            end
            if (dmem_en && !dmem_we) begin
                rdN++;
                rdA = dmem_addr;
            end
            if (!dmem_en && dmem_addr != 5'd0) addrBad++;
            if (exec_ready) break;
        end
    endtask

    int         lat, pcN, wrN, rdN, addrBad;
    logic [4:0] pcV, wrA, rdA;
    logic [7:0] wrD;

    initial begin
        //           instr  mem    acc    z     c     lat pc pcVal  wr rd
        vecs[0]  = '{8'h23, 8'h05, 8'h05, 1'b0, 1'b0, 4, 0, 5'h00, 0, 1};  // LDA 3
        vecs[1]  = '{8'h25, 8'hF0, 8'hF0, 1'b0, 1'b0, 4, 0, 5'h00, 0, 1};  // LDA 5
        vecs[2]  = '{8'h64, 8'h20, 8'h10, 1'b0, 1'b1, 4, 0, 5'h00, 0, 1};  // ADD 4 carry
        vecs[3]  = '{8'h84, 8'h10, 8'h00, 1'b1, 1'b0, 4, 0, 5'h00, 0, 1};  // SUB 4 -> 0
        vecs[4]  = '{8'hD2, 8'h00, 8'h00, 1'b1, 1'b0, 2, 1, 5'h12, 0, 0};  // JZ taken
        vecs[5]  = '{8'h26, 8'h5A, 8'h5A, 1'b0, 1'b0, 4, 0, 5'h00, 0, 1};  // LDA 6
        vecs[6]  = '{8'hD2, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 0, 5'h00, 0, 0};  // JZ not taken
        vecs[7]  = '{8'hA7, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 1, 5'h07, 0, 0};  // JMP 7
        vecs[8]  = '{8'h49, 8'h00, 8'h5A, 1'b0, 1'b0, 3, 0, 5'h00, 1, 0};  // STA 9
        vecs[9]  = '{8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 2, 0, 5'h00, 0, 0};  // NOP
        vecs[10] = '{8'h82, 8'h5B, 8'hFF, 1'b0, 1'b1, 4, 0, 5'h00, 0, 1};  // SUB borrow
        vecs[11] = '{8'h61, 8'h01, 8'h00, 1'b1, 1'b1, 4, 0, 5'h00, 0, 1};  // ADD wrap to 0
        vecs[12] = '{8'h23, 8'h05, 8'h05, 1'b0, 1'b1, 4, 0, 5'h00, 0, 1};  // LDA keeps c
        vecs[13] = '{8'h9F, 8'h06, 8'hFF, 1'b0, 1'b1, 4, 0, 5'h00, 0, 1};  // SUB 31
        vecs[14] = '{8'h5F, 8'h00, 8'hFF, 1'b0, 1'b1, 3, 0, 5'h00, 1, 0};  // STA 31

        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_in    = 8'h00;

        // Reset state, held across a clock edge
        #12;
        check("rst ready",   32'(exec_ready),  32'd1);
        check("rst dmem_en", 32'(dmem_en),     32'd0);
        check("rst dmem_we", 32'(dmem_we),     32'd0);
        check("rst addr",    32'(dmem_addr),   32'd0);
        check("rst pc_load", 32'(pc_load),     32'd0);
        check("rst pc_val",  32'(pc_load_val), 32'd0);
        check("rst halted",  32'(halted),      32'd0);
        check("rst acc",     32'(acc_out),     32'd0);
        check("rst z",       32'(z_flag),      32'd1);
        check("rst c",       32'(c_flag),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Vector table, issued back to back
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].expRd > 0) mem[vecs[i].instr[4:0]] = vecs[i].memVal;
            check($sformatf("v%0d ready", i), 32'(exec_ready), 32'd1);
            runInstr(vecs[i].instr, lat, pcN, pcV, wrN, wrA, wrD, rdN, rdA, addrBad);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            check($sformatf("v%0d acc", i), 32'(acc_out), 32'(vecs[i].expAcc));
            check($sformatf("v%0d z", i), 32'(z_flag), 32'(vecs[i].expZ));
            check($sformatf("v%0d c", i), 32'(c_flag), 32'(vecs[i].expC));
            check($sformatf("v%0d pc pulses", i), 32'(pcN), 32'(vecs[i].expPc));
            if (vecs[i].expPc > 0)
                check($sformatf("v%0d pc value", i), 32'(pcV), 32'(vecs[i].expPcVal));
            check($sformatf("v%0d writes", i), 32'(wrN), 32'(vecs[i].expWr));
            if (vecs[i].expWr > 0) begin
                check($sformatf("v%0d wr addr", i), 32'(wrA), 32'(vecs[i].instr[4:0]));
                check($sformatf("v%0d wr data", i), 32'(wrD), 32'(vecs[i].expAcc));
            end
            check($sformatf("v%0d reads", i), 32'(rdN), 32'(vecs[i].expRd));
            if (vecs[i].expRd > 0)
                check($sformatf("v%0d rd addr", i), 32'(rdA), 32'(vecs[i].instr[4:0]));
            check($sformatf("v%0d idle addr", i), 32'(addrBad), 32'd0);
        end

        // HLT: halts for good, ignores further instr_valid
        instr_in    = 8'hE0;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        check("hlt decode halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("hlt halted", 32'(halted),     32'd1);
        check("hlt ready",  32'(exec_ready), 32'd0);
        instr_in    = 8'h23;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("hlt hold halted %0d", k), 32'(halted),     32'd1);
            check($sformatf("hlt hold ready %0d", k),  32'(exec_ready), 32'd0);
            check($sformatf("hlt hold en %0d", k),     32'(dmem_en),    32'd0);
            check($sformatf("hlt hold acc %0d", k),    32'(acc_out),    32'h0FF);
        end
        instr_valid = 1'b0;
        instr_in    = 8'h00;

        // Asynchronous reset out of HALT, checked before any clock edge
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("hlt rst halted", 32'(halted),     32'd0);
        check("hlt rst ready",  32'(exec_ready), 32'd1);
        check("hlt rst acc",    32'(acc_out),    32'd0);
        check("hlt rst z",      32'(z_flag),     32'd1);
        check("hlt rst c",      32'(c_flag),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during MEM_RD of an ADD abandons the instruction
        mem[3] = 8'h05;
        runInstr(8'h23, lat, pcN, pcV, wrN, wrA, wrD, rdN, rdA, addrBad);
        check("pre-add acc", 32'(acc_out), 32'h05);
        instr_in    = 8'h63;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("memrd en",   32'(dmem_en),   32'd1);
        check("memrd we",   32'(dmem_we),   32'd0);
        check("memrd addr", 32'(dmem_addr), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check("memrd rst en",    32'(dmem_en),    32'd0);
        check("memrd rst addr",  32'(dmem_addr),  32'd0);
        check("memrd rst ready", 32'(exec_ready), 32'd1);
        check("memrd rst acc",   32'(acc_out),    32'd0);
        check("memrd rst z",     32'(z_flag),     32'd1);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post rst acc %0d", k),   32'(acc_out),    32'd0);
            check($sformatf("post rst z %0d", k),     32'(z_flag),     32'd1);
            check($sformatf("post rst en %0d", k),    32'(dmem_en),    32'd0);
            check($sformatf("post rst ready %0d", k), 32'(exec_ready), 32'd1);
        end

        // Machine still works afterwards
        runInstr(8'h23, lat, pcN, pcV, wrN, wrA, wrD, rdN, rdA, addrBad);
        check("recover latency", 32'(lat),     32'd4);
        check("recover acc",     32'(acc_out), 32'h05);
        check("recover z",       32'(z_flag),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMis);
        $finish;
    end

endmodule
